// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - PWM DAC turning NCO codes into fixed-length PWM windows on a single pin
// Optional sample counter output enabled by defining PWM_DAC_SAMPLE_COUNT_EN.
module pwm_dac #(
    parameter int CODE_WIDTH        = 10,
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CNT_WIDTH         = $clog2(CYCLES_PER_WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  active
`ifdef PWM_DAC_SAMPLE_COUNT_EN
    ,
    output logic [31:0]           sample_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(CYCLES_PER_WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_STROBE = CNT_WIDTH'(CYCLES_PER_WINDOW - 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic                    pwm_q, pwm_d;
    logic                    next_sample_q, next_sample_d;
    logic [CODE_WIDTH-1:0]   cnt_ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    code_d  = code;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        code_d = code;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered pwm lines up with cnt.
    always_comb begin
        cnt_ext       = CODE_WIDTH'(cnt_d);
        pwm_d         = (state_d == RUN) && (cnt_ext < code_d);
        next_sample_d = (state_d == RUN) && (cnt_d == CNT_STROBE) && en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            code_q        <= '0;
            pwm_q         <= 1'b0;
            next_sample_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            pwm_q         <= pwm_d;
            next_sample_q <= next_sample_d;
        end
    end

    assign pwm         = pwm_q;
    assign next_sample = next_sample_q;
    assign active      = (state_q == RUN);

`ifdef PWM_DAC_SAMPLE_COUNT_EN
    logic        latch;
    logic [31:0] sample_count_q, sample_count_d;

    // A code latch happens on window start from IDLE and on every enabled wrap.
    always_comb begin
        latch          = en && ((state_q == IDLE) || (cnt_q == CNT_LAST));
        sample_count_d = sample_count_q + 32'(latch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count_q <= '0;
        end else begin
            sample_count_q <= sample_count_d;
        end
    end

    assign sample_count = sample_count_q;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// tb/tb_pwm_dac.sv - self-checking bench for pwm_dac with a window-level reference model
module tb_pwm_dac;

    localparam int CW  = 10;
    localparam int CPW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] code = '0;
    logic          next_sample;
    logic          pwm;
    logic          active;
`ifdef PWM_DAC_SAMPLE_COUNT_EN
    logic [31:0]   sample_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pwm_dac #(
        .CODE_WIDTH(CW),
        .CYCLES_PER_WINDOW(CPW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .code(code),
        .next_sample(next_sample),
        .pwm(pwm),
        .active(active)
`ifdef PWM_DAC_SAMPLE_COUNT_EN
        ,
        .sample_count(sample_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: running flag, position inside the window, code owned by the window.
    int          m_run  = 0;
    int          m_k    = 0;
    int          m_code = 0;
    int          m_ns   = 0;
    int unsigned m_scnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_k = 0; m_code = 0; m_ns = 0; m_scnt = 0;
        end else begin
            if (m_run == 0) begin
                if (en) begin
                    m_run = 1; m_k = 0; m_code = int'(code); m_scnt++;
                end
            end else if (m_k == CPW - 1) begin
                m_k = 0;
                if (en) begin
                    m_code = int'(code); m_scnt++;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_k++;
            end
            m_ns = (m_run != 0 && en && m_k == CPW - 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("pwm",         32'(pwm),         (m_run != 0 && m_k < m_code) ? 32'd1 : 32'd0);
        chk("next_sample", 32'(next_sample), 32'(m_ns));
        chk("active",      32'(active),      32'(m_run));
`ifdef PWM_DAC_SAMPLE_COUNT_EN
        chk("sample_count", sample_count, m_scnt);
`endif
    end

    // Bit i of each expectation is window-relative cycle i.
    task automatic run_window(input string tag, input int n, input logic [31:0] e_pwm,
                              input logic [31:0] e_ns, input logic [31:0] e_act);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_pwm"}, 32'(pwm),         32'(e_pwm[i]));
            chk({tag, "_ns"},  32'(next_sample), 32'(e_ns[i]));
            chk({tag, "_act"}, 32'(active),      32'(e_act[i]));
        end
    endtask

    task automatic go_idle();
        bit done = 0;
        en = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (m_run == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset held with en high and a large code
        en = 1'b1; code = 10'd500; rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pwm", 32'(pwm), 32'd0);
            chk("rst_act", 32'(active), 32'd0);
            chk("rst_ns",  32'(next_sample), 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1; en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_act", 32'(active), 32'd0);
            chk("post_rst_pwm", 32'(pwm), 32'd0);
        end

        // Steady state, code 3: two windows of 1,1,1,0,0,0,0,0
        code = 10'd3; en = 1'b1;
        @(posedge clk);
        run_window("steady", 16, 32'h0707, 32'h4040, 32'hFFFF);

        // Saturation both ways
        go_idle();
        code = 10'd0; en = 1'b1;
        @(posedge clk);
        run_window("sat0", 8, 32'h00, 32'h40, 32'hFF);
        code = 10'd1023;
        run_window("sat1", 8, 32'hFF, 32'h40, 32'hFF);

        // NCO update on the edge ending the strobe cycle
        go_idle();
        code = 10'd2; en = 1'b1;
        @(posedge clk);
        run_window("upd_a", 7, 32'h03, 32'h40, 32'h7F);
        @(posedge clk); #1;
        code = 10'd5;
        run_window("upd_b", 9, 32'h03E, 32'h080, 32'h1FF);

        // Disable mid-window, then restart with the current code
        go_idle();
        code = 10'd4; en = 1'b1;
        @(posedge clk);
        run_window("dis_a", 4, 32'hF, 32'h0, 32'hF);
        en = 1'b0;
        run_window("dis_b", 6, 32'h00, 32'h00, 32'h0F);
        code = 10'd7; en = 1'b1;
        @(posedge clk);
        run_window("dis_c", 8, 32'h7F, 32'h40, 32'hFF);

        // Asynchronous reset mid-window with code 6
        code = 10'd6;
        run_window("ar", 3, 32'h7, 32'h0, 32'h7);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_pwm", 32'(pwm), 32'd0);
        chk("ar_act", 32'(active), 32'd0);
        chk("ar_ns",  32'(next_sample), 32'd0);
`ifdef PWM_DAC_SAMPLE_COUNT_EN
        chk("ar_scnt", sample_count, 32'd0);
`endif
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk);
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            chk("restart_pwm", 32'(pwm), 32'd1);
`ifdef PWM_DAC_SAMPLE_COUNT_EN
            chk("restart_scnt", sample_count, 32'(w));
`endif
            repeat (7) @(negedge clk);
        end

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) code = CW'($urandom_range(0, 1023));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
